// File: rtl/propose_corner_point_seq.sv
// -----------------------------------------------------------------------------
// propose_corner_point_seq
//   Time-multiplexed corner-point proposer for the stochastic-search MCMC move.
//   A bank of NUM_CLAUSES integer-literal clauses (sum a_k*x_k + b >= 0) is
//   reduced one clause per cycle against a latched assignment for a chosen
//   variable x_v. The tightest lower/upper bounds on x_v are tracked, and one
//   corner of the resulting interval is proposed per start handshake.
//
// Ports
//   in_clk                  clock, rising edge
//   in_reset                synchronous active-high reset
//   in_clause_wr_en         write one clause slot (ignored while busy)
//   in_clause_index         slot to write (out-of-range indices dropped)
//   in_clause_coefficients  {b, a[NUM_VARS-1] .. a[0]}, a[0] in LSBs
//   in_start                request a proposal (sampled in IDLE only)
//   in_assignment           current assignment, x0 in LSBs
//   in_var_index            chosen variable v
//   in_clause_enable        per-clause participation mask
//   in_random_bit           corner select when both bounds exist (1 = upper)
//   out_busy                high from the cycle after accept through DONE
//   out_valid               one-cycle result pulse
//   out_new_value           proposed value for x_v
//   out_lower_found         at least one lower bound seen
//   out_upper_found         at least one upper bound seen
//   out_conflict            lower > upper, value falls back to current x_v
//   out_saturated           chosen bound was clipped to the VAR_W range
// -----------------------------------------------------------------------------
module propose_corner_point_seq #(
    parameter int COEF_W       = 8,
    parameter int VAR_IDX_W    = 2,
    parameter int VAR_W        = 8,
    parameter int NUM_CLAUSES  = 8,
    parameter int CLAUSE_IDX_W = 3
) (
    input  logic                                   in_clk,
    input  logic                                   in_reset,
    input  logic                                   in_clause_wr_en,
    input  logic [CLAUSE_IDX_W-1:0]                in_clause_index,
    input  logic [(2**VAR_IDX_W+1)*COEF_W-1:0]     in_clause_coefficients,
    input  logic                                   in_start,
    input  logic [(2**VAR_IDX_W)*VAR_W-1:0]        in_assignment,
    input  logic [VAR_IDX_W-1:0]                   in_var_index,
    input  logic [NUM_CLAUSES-1:0]                 in_clause_enable,
    input  logic                                   in_random_bit,
    output logic                                   out_busy,
    output logic                                   out_valid,
    output logic [VAR_W-1:0]                       out_new_value,
    output logic                                   out_lower_found,
    output logic                                   out_upper_found,
    output logic                                   out_conflict,
    output logic                                   out_saturated
);

    localparam int NUM_VARS = 2**VAR_IDX_W;
    localparam int CL_W     = (NUM_VARS + 1) * COEF_W;
    localparam int ACC_W    = COEF_W + VAR_W + VAR_IDX_W + 1;
    localparam int VMAX_I   = 2**(VAR_W-1) - 1;
    localparam logic signed [ACC_W-1:0] VMAX = ACC_W'(VMAX_I);
    localparam logic signed [ACC_W-1:0] VMIN = ACC_W'(-VMAX_I - 1);
    localparam logic [CLAUSE_IDX_W-1:0] LAST_IDX = CLAUSE_IDX_W'(NUM_CLAUSES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;
    typedef enum logic [1:0] {K_NONE, K_LOWER, K_UPPER} kind_t;

    state_t state_q, state_d;

    logic [CL_W-1:0]               clause_mem [NUM_CLAUSES];
    logic [NUM_VARS*VAR_W-1:0]     asg_q;
    logic [VAR_IDX_W-1:0]          var_q;
    logic [NUM_CLAUSES-1:0]        en_q;
    logic                          rnd_q;
    logic [CLAUSE_IDX_W-1:0]       scan_idx;

    logic                          s1_valid;
    kind_t                         s1_kind;
    logic signed [ACC_W-1:0]       s1_r;
    logic signed [ACC_W-1:0]       lower_q, upper_q;
    logic                          lower_found, upper_found;

    logic [VAR_W-1:0]              hold_value;
    logic                          hold_lf, hold_uf, hold_cf, hold_sat;

    logic                          start_accept;
    logic                          idx_in_range;
    logic [CL_W-1:0]               cl_rd;
    logic signed [COEF_W-1:0]      a_v;
    kind_t                         kind_d;
    logic signed [ACC_W-1:0]       r_d;

    logic [VAR_W-1:0]              res_value;
    logic                          res_conflict, res_sat;

    // b + sum over k != v of a_k*x_k, all terms sign-extended to ACC_W first
    // so no partial sum can overflow.
    function automatic logic signed [ACC_W-1:0] reduce_clause(
        input logic [CL_W-1:0]           cl,
        input logic [NUM_VARS*VAR_W-1:0] asg,
        input logic [VAR_IDX_W-1:0]      v
    );
        logic signed [ACC_W-1:0]  acc;
        logic signed [COEF_W-1:0] a_k;
        logic signed [VAR_W-1:0]  x_k;
        acc = ACC_W'($signed(cl[NUM_VARS*COEF_W +: COEF_W]));
        for (int k = 0; k < NUM_VARS; k++) begin
            a_k = cl[k*COEF_W +: COEF_W];
            x_k = asg[k*VAR_W +: VAR_W];
            if (VAR_IDX_W'(k) != v) acc = acc + ACC_W'(a_k) * ACC_W'(x_k);
        end
        return acc;
    endfunction

    generate
        if (NUM_CLAUSES < 2**CLAUSE_IDX_W) begin : g_idx_chk
            assign idx_in_range = int'(in_clause_index) < NUM_CLAUSES;
        end else begin : g_idx_full
            assign idx_in_range = 1'b1;
        end
    endgenerate

    assign start_accept = (state_q == S_IDLE) && in_start;

    // ---------------- FSM ----------------
    always_ff @(posedge in_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (in_reset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_d   = state_q;
        out_busy  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  if (in_start) state_d = S_SCAN;
            S_SCAN:  begin
                out_busy = 1'b1;
                if (scan_idx == LAST_IDX) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                out_busy = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE:  begin
                out_busy  = 1'b1;
                out_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- stage 1 input: one clause per SCAN cycle ----------------
    always_comb begin
        cl_rd  = clause_mem[scan_idx];
        a_v    = cl_rd[var_q*COEF_W +: COEF_W];
        r_d    = reduce_clause(cl_rd, asg_q, var_q);
        kind_d = K_NONE;
        if (en_q[scan_idx]) begin
            if (a_v == COEF_W'(1))       kind_d = K_LOWER;
            else if (a_v == {COEF_W{1'b1}}) kind_d = K_UPPER;
        end
    end

    // ---------------- result selection (valid in DONE) ----------------
    always_comb begin
        logic signed [ACC_W-1:0] chosen;
        logic                    use_bound;
        res_conflict = lower_found && upper_found && (lower_q > upper_q);
        res_sat      = 1'b0;
        res_value    = asg_q[var_q*VAR_W +: VAR_W];
        chosen       = lower_q;
        use_bound    = 1'b1;
        if (lower_found && upper_found) begin
            if (res_conflict) use_bound = 1'b0;
            else if (rnd_q)   chosen = upper_q;
        end else if (upper_found) begin
            chosen = upper_q;
        end else if (!lower_found) begin
            use_bound = 1'b0;
        end
        if (use_bound) begin
            if (chosen > VMAX) begin
                res_value = VAR_W'(VMAX);
                res_sat   = 1'b1;
            end else if (chosen < VMIN) begin
                res_value = VAR_W'(VMIN);
                res_sat   = 1'b1;
            end else begin
                res_value = VAR_W'(chosen);
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            // NOTE: the clause bank must read as all-zero after reset, so it
            // is built from flops with an explicit clear rather than a RAM.
            for (int i = 0; i < NUM_CLAUSES; i++) clause_mem[i] <= '0;
            asg_q       <= '0;
            var_q       <= '0;
            en_q        <= '0;
            rnd_q       <= 1'b0;
            scan_idx    <= '0;
            s1_valid    <= 1'b0;
            s1_kind     <= K_NONE;
            s1_r        <= '0;
            lower_q     <= '0;
            upper_q     <= '0;
            lower_found <= 1'b0;
            upper_found <= 1'b0;
            hold_value  <= '0;
            hold_lf     <= 1'b0;
            hold_uf     <= 1'b0;
            hold_cf     <= 1'b0;
            hold_sat    <= 1'b0;
        end else begin
            if (in_clause_wr_en && !out_busy && idx_in_range)
                clause_mem[in_clause_index] <= in_clause_coefficients;

            if (start_accept) begin
                asg_q       <= in_assignment;
                var_q       <= in_var_index;
                en_q        <= in_clause_enable;
                rnd_q       <= in_random_bit;
                scan_idx    <= '0;
                lower_found <= 1'b0;
                upper_found <= 1'b0;
            end else if (state_q == S_SCAN) begin
                scan_idx <= scan_idx + 1'b1;
            end

            // Stage 1 register; the DRAIN cycle lets the last clause retire.
            s1_valid <= (state_q == S_SCAN);
            s1_kind  <= kind_d;
            s1_r     <= r_d;

            // Stage 2: a_v=+1 gives x_v >= -r, a_v=-1 gives x_v <= r.
            if (s1_valid) begin
                if (s1_kind == K_LOWER && (!lower_found || -s1_r > lower_q)) begin
                    lower_q     <= -s1_r;
                    lower_found <= 1'b1;
                end
                if (s1_kind == K_UPPER && (!upper_found || s1_r < upper_q)) begin
                    upper_q     <= s1_r;
                    upper_found <= 1'b1;
                end
            end

            if (state_q == S_DONE) begin
                hold_value <= res_value;
                hold_lf    <= lower_found;
                hold_uf    <= upper_found;
                hold_cf    <= res_conflict;
                hold_sat   <= res_sat;
            end
        end
    end

    // Live result during DONE, held copy afterwards.
    assign out_new_value   = (state_q == S_DONE) ? res_value    : hold_value;
    assign out_lower_found = (state_q == S_DONE) ? lower_found  : hold_lf;
    assign out_upper_found = (state_q == S_DONE) ? upper_found  : hold_uf;
    assign out_conflict    = (state_q == S_DONE) ? res_conflict : hold_cf;
    assign out_saturated   = (state_q == S_DONE) ? res_sat      : hold_sat;

endmodule

// File: tb/tb_propose_corner_point_seq.sv
// -----------------------------------------------------------------------------
// tb_propose_corner_point_seq
//   Directed bench for propose_corner_point_seq (default parameters). A
//   behavioural model computes each proposal from the clause/bound rules; a
//   single compare process checks valid/busy timing and the result fields on
//   every cycle outside reset, plus hand-computed literals on each valid pulse.
// -----------------------------------------------------------------------------
module tb_propose_corner_point_seq;

    logic        clk = 1'b0;
    logic        in_reset;
    logic        in_clause_wr_en;
    logic [2:0]  in_clause_index;
    logic [39:0] in_clause_coefficients;
    logic        in_start;
    logic [31:0] in_assignment;
    logic [1:0]  in_var_index;
    logic [7:0]  in_clause_enable;
    logic        in_random_bit;
    logic        out_busy, out_valid;
    logic [7:0]  out_new_value;
    logic        out_lower_found, out_upper_found, out_conflict, out_saturated;

    propose_corner_point_seq dut (
        .in_clk                 (clk),
        .in_reset               (in_reset),
        .in_clause_wr_en        (in_clause_wr_en),
        .in_clause_index        (in_clause_index),
        .in_clause_coefficients (in_clause_coefficients),
        .in_start               (in_start),
        .in_assignment          (in_assignment),
        .in_var_index           (in_var_index),
        .in_clause_enable       (in_clause_enable),
        .in_random_bit          (in_random_bit),
        .out_busy               (out_busy),
        .out_valid              (out_valid),
        .out_new_value          (out_new_value),
        .out_lower_found        (out_lower_found),
        .out_upper_found        (out_upper_found),
        .out_conflict           (out_conflict),
        .out_saturated          (out_saturated)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, acc_cyc = 0, valid_seen = 0, timeouts = 0, seen_to = 0;
    bit pending = 0;

    // model results and hand literals for the proposal in flight
    int exp_val;  bit exp_lf, exp_uf, exp_cf, exp_sat;
    int lit_val;  bit lit_lf, lit_uf, lit_cf, lit_sat;
    // values the DUT must currently be holding
    int h_val;    bit h_lf, h_uf, h_cf, h_sat;

    int m_a [8][4];
    int m_b [8];
    int cur_x [4];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    // Interval rules: a_v=+1 -> x_v >= -r, a_v=-1 -> x_v <= r.
    function automatic void model(input int v, input logic [7:0] en, input bit rnd,
                                  output int val, output bit lf, output bit uf,
                                  output bit cf, output bit sat);
        int lo, hi, r, ch;
        bit use_b;
        lf = 0; uf = 0; cf = 0; sat = 0; lo = 0; hi = 0; ch = 0;
        val = cur_x[v];
        for (int c = 0; c < 8; c++) begin
            if (en[c] && (m_a[c][v] == 1 || m_a[c][v] == -1)) begin
                r = m_b[c];
                for (int k = 0; k < 4; k++) if (k != v) r += m_a[c][k] * cur_x[k];
                if (m_a[c][v] == 1) begin
                    if (!lf || -r > lo) lo = -r;
                    lf = 1;
                end else begin
                    if (!uf || r < hi) hi = r;
                    uf = 1;
                end
            end
        end
        use_b = 1;
        if (lf && uf) begin
            if (lo > hi) begin cf = 1; use_b = 0; end
            else ch = rnd ? hi : lo;
        end else if (lf) ch = lo;
        else if (uf) ch = hi;
        else use_b = 0;
        if (use_b) begin
            if (ch > 127)       begin val = 127;  sat = 1; end
            else if (ch < -128) begin val = -128; sat = 1; end
            else val = ch;
        end
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin : cmp
        bit ev, eb;
        cyc++;
        if (in_reset) begin
            h_val = 0; h_lf = 0; h_uf = 0; h_cf = 0; h_sat = 0;
        end else begin
            ev = pending && (cyc - acc_cyc == 10);
            eb = pending && (cyc - acc_cyc >= 1) && (cyc - acc_cyc <= 10);
            check("out_valid", out_valid, ev);
            check("out_busy", out_busy, eb);
            if (ev) begin
                h_val = exp_val; h_lf = exp_lf; h_uf = exp_uf; h_cf = exp_cf; h_sat = exp_sat;
                check("lit_value",     $signed(out_new_value), lit_val);
                check("lit_lower",     out_lower_found, lit_lf);
                check("lit_upper",     out_upper_found, lit_uf);
                check("lit_conflict",  out_conflict,    lit_cf);
                check("lit_saturated", out_saturated,   lit_sat);
                valid_seen++;
            end
            check("new_value",   $signed(out_new_value), h_val);
            check("lower_found", out_lower_found, h_lf);
            check("upper_found", out_upper_found, h_uf);
            check("conflict",    out_conflict,    h_cf);
            check("saturated",   out_saturated,   h_sat);
        end
        if (timeouts != seen_to) begin
            check("valid_timeout", timeouts, seen_to);
            seen_to = timeouts;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input int idx, input int a0, input int a1, input int a2,
                      input int a3, input int b);
        in_clause_wr_en        = 1'b1;
        in_clause_index        = 3'(idx);
        in_clause_coefficients = {8'(b), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        @(posedge clk); #1;
        in_clause_wr_en = 1'b0;
        m_a[idx][0] = a0; m_a[idx][1] = a1; m_a[idx][2] = a2; m_a[idx][3] = a3;
        m_b[idx] = b;
    endtask

    task automatic apply_start(input int x0, input int x1, input int x2, input int x3,
                               input int v, input logic [7:0] en, input bit rnd);
        cur_x[0] = x0; cur_x[1] = x1; cur_x[2] = x2; cur_x[3] = x3;
        model(v, en, rnd, exp_val, exp_lf, exp_uf, exp_cf, exp_sat);
        in_assignment    = {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
        in_var_index     = 2'(v);
        in_clause_enable = en;
        in_random_bit    = rnd;
        in_start         = 1'b1;
        @(posedge clk);
        acc_cyc = cyc;
        pending = 1;
        #1;
        in_start         = 1'b0;
        in_assignment    = $urandom;
        in_var_index     = 2'($urandom_range(0, 3));
        in_clause_enable = 8'($urandom);
        in_random_bit    = ~rnd;
    endtask

    // poke: hold in_start and a slot-0 write high during the first busy cycles
    task automatic run(input int x0, input int x1, input int x2, input int x3,
                       input int v, input logic [7:0] en, input bit rnd, input bit poke,
                       input int lv, input bit llf, input bit luf, input bit lcf,
                       input bit lsat);
        int seen;
        lit_val = lv; lit_lf = llf; lit_uf = luf; lit_cf = lcf; lit_sat = lsat;
        apply_start(x0, x1, x2, x3, v, en, rnd);
        seen = valid_seen;
        for (int i = 0; i < 40 && valid_seen == seen; i++) begin
            if (poke) begin
                in_start               = (i < 4);
                in_clause_wr_en        = (i < 4);
                in_clause_index        = 3'd0;
                in_clause_coefficients = {8'(-100), 8'd0, 8'd0, 8'd0, 8'd1};
            end
            @(posedge clk); #1;
        end
        in_start        = 1'b0;
        in_clause_wr_en = 1'b0;
        if (valid_seen == seen) timeouts++;
        pending = 0;
    endtask

    task automatic do_reset(input int cycles);
        in_reset = 1'b1;
        pending  = 0;
        repeat (cycles) @(posedge clk);
        #1;
        in_reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            m_b[c] = 0;
            for (int k = 0; k < 4; k++) m_a[c][k] = 0;
        end
    endtask

    initial begin
        in_clause_wr_en = 0; in_clause_index = 0; in_clause_coefficients = 0;
        in_start = 0; in_assignment = 0; in_var_index = 0;
        in_clause_enable = 0; in_random_bit = 0;
        do_reset(3);
        repeat (3) @(posedge clk);
        #1;

        wr(0, 1, 1, 0, 0, -5);
        wr(1, -1, 0, 0, 0, 7);
        // T1 / T2: both bounds [3,7]
        run(0, 2, 0, 0, 0, 8'h03, 0, 0, 3, 1, 1, 0, 0);
        run(0, 2, 0, 0, 0, 8'h03, 1, 0, 7, 1, 1, 0, 0);
        run(0, 2, 0, 0, 0, 8'h01, 1, 0, 3, 1, 0, 0, 0);
        // T3: lower raised to 9 > upper 7
        wr(2, 1, 0, 0, 0, -9);
        run(0, 2, 0, 0, 0, 8'h07, 0, 0, 0, 1, 1, 1, 0);
        // T4: lower 255 clips high; upper -255 clips low
        wr(3, 1, -1, 0, 0, -128);
        run(0, 127, 0, 0, 0, 8'h08, 0, 0, 127, 1, 0, 0, 1);
        wr(4, -1, -1, 0, 0, -128);
        run(0, 127, 0, 0, 0, 8'h10, 1, 0, -128, 0, 1, 0, 1);
        // T5: no clause enabled; extra starts and a write while busy are ignored
        run(0, 2, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
        run(-7, 2, 0, 0, 0, 8'h00, 1, 0, -7, 0, 0, 0, 0);
        run(0, 2, 0, 0, 0, 8'h03, 0, 0, 3, 1, 1, 0, 0);
        // v = 1: slot0 gives x1 >= 5, slot1 has a1 = 0
        run(0, 2, 0, 0, 1, 8'h03, 1, 0, 5, 1, 0, 0, 0);

        // T6: reset in the middle of a scan, then reload and repeat T1
        apply_start(0, 2, 0, 0, 0, 8'h03, 0);
        repeat (4) @(posedge clk);
        #1;
        do_reset(2);
        repeat (15) @(posedge clk);
        #1;
        wr(0, 1, 1, 0, 0, -5);
        wr(1, -1, 0, 0, 0, 7);
        run(0, 2, 0, 0, 0, 8'h03, 0, 0, 3, 1, 1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
